uart_tx_on_change: RTL and testbench
====================================

Name: uart_tx_on_change

Overview:
- Downstream consumer of the switch-to-byte transport stage.
- Watches the registered 8-bit data byte and serialises each new value on a UART line (8N1, LSB first).
- Lets the board report switch changes to a host PC.
- Holds one pending byte so a change that arrives mid-frame is not lost.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Legal range 2..65535.
- CNT_W, 16, width of the bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- data_in  input  8  byte from the transport stage; may change on any clock edge
- tx  output  1  UART serial line; idles high
- busy  output  1  high while a frame is being shifted out
- overrun  output  1  one-cycle pulse when an unsent pending byte is overwritten

Behaviour:
- Reset (asynchronous, while rst=1):
  - Outputs: tx=1, busy=0, overrun=0.
  - Internal: prev_q=8'h00, pending_valid=0, state=IDLE, counters=0.
- Change detect:
  - prev_q<=data_in on every edge.
  - A change is flagged on edge k when data_in != prev_q.
  - A nonzero data_in after reset release is therefore sent once.
- FSM states:
  - IDLE: tx=1, busy=0. On change at edge k: shift_q<=data_in, state<=START, tx<=0, busy<=1. tx falls at edge k (latency 0 cycles after the sampling edge).
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx=shift_q[bit_idx] for CLKS_PER_BIT cycles per bit, LSB first. After bit 7, go to STOP (or PARITY if enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
    - pending_valid=1: shift_q<=pending_q, clear pending_valid, state<=START; tx falls on the same edge, with no idle gap.
    - Otherwise: state<=IDLE, busy<=0.
- Frame length: 10*CLKS_PER_BIT cycles, with busy high for all of them.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Change while busy:
  - pending_q<=data_in and pending_valid<=1.
  - If pending_valid was already 1, pending_q is overwritten (newest wins) and overrun pulses for one cycle.
- Simultaneous change and end of STOP on the same edge:
  - The new data_in is loaded directly into shift_q and sent next.
  - pending_q, if valid, is discarded with an overrun pulse.
  - Newest value always wins.
- Reset mid-frame: tx returns to 1 immediately and the frame is abandoned. No partial-frame recovery.
- The byte in shift_q is held stable for the whole frame and is unaffected by later data_in changes.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx=^shift_q (even parity) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; 8N1 only.

Decomposition:
- Package uart_pkg holds:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Constants: DATA_BITS=8, STOP_BITS=1, IDLE_LEVEL=1'b1.
- Sub-module uart_baud_cnt:
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clk, rst, clear.
  - Output: bit_done, a 1-cycle pulse when count==CLKS_PER_BIT-1.
  - The FSM uses clear to restart the counter at frame start.

Test Plan (CLKS_PER_BIT=4):
- Reset release with data_in=8'h00, held 50 cycles -> tx=1, busy=0 throughout; no frame.
- data_in 8'h00->8'h05 at edge k:
  - tx=0 for cycles k..k+3.
  - Then bits 1,0,1,0,0,0,0,0 at 4 cycles each, then stop=1.
  - busy falls at k+40.
- 8'h03 then 8'h07 at k+10 (mid-frame) -> 8'h03 frame completes; 8'h07 frame starts at k+40 with no idle gap; overrun stays 0.
- 8'h01, then 8'h02 at k+8, then 8'h04 at k+12 -> overrun pulses once at k+12; frames sent are 8'h01 then 8'h04; 8'h02 is dropped.
- rst asserted at k+20 during a frame -> tx=1, busy=0 immediately. After release with data_in=8'h06 unchanged from before reset, one 8'h06 frame is sent, because prev_q was reset to 0.
- UART_TX_PARITY_EN defined, send 8'h07 -> parity bit 1 at cycles k+36..k+39; stop bit follows; busy falls at k+44.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter that reports switch changes.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit (8E1).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_on_change_if.sv
// Data/line bundle between the switch transport stage, the transmitter and its observer.
interface uart_tx_on_change_if;
    logic [7:0] data_in;
    logic       tx;
    logic       busy;
    logic       overrun;

    // Producer side: drives the byte, watches the line.
    modport master (output data_in, input tx, input busy, input overrun);
    // Transmitter side.
    modport slave  (input data_in, output tx, output busy, output overrun);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: pulses bit_done on the last clock of every UART bit.
// CNT_W must be wide enough that 2**CNT_W > CLKS_PER_BIT.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap; clear pins it to 0 so a frame starts on a fresh bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign bit_done = (cnt == LAST);
endmodule

// File: rtl/uart_tx_on_change.sv
// Serialises every change of the incoming byte on a UART line (8N1, LSB first).
// One pending slot absorbs a change that arrives mid-frame; newest value wins.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_on_change
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_on_change_if.slave   bus
);
    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = PARITY;
`endif
    localparam logic [2:0] S_STOP   = STOP;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [2:0] state;
    logic [7:0] prev_q;
    logic [7:0] shift_q;
    logic [7:0] pending_q;
    logic       pending_valid;
    logic [2:0] bit_idx;
    logic       tx_q;
    logic       busy_q;
    logic       overrun_q;
    logic       change;
    logic       bit_done;
    logic       stop_end;

    assign change   = (bus.data_in != prev_q);
    assign stop_end = (state == S_STOP) && bit_done;

    // Counter is held at zero while idle, so the start bit always gets a full period.
    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == S_IDLE),
        .bit_done (bit_done)
    );

    // Frame sequencer, change detector and pending-slot management.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            prev_q        <= 8'h00;
            shift_q       <= 8'h00;
            pending_q     <= 8'h00;
            pending_valid <= 1'b0;
            bit_idx       <= 3'd0;
            tx_q          <= IDLE_LEVEL;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            prev_q    <= bus.data_in;
            overrun_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (change) begin
                        shift_q <= bus.data_in;
                        state   <= S_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state   <= S_DATA;
                        bit_idx <= 3'd0;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx_q  <= ^shift_q;
`else
                            state <= S_STOP;
                            tx_q  <= IDLE_LEVEL;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shift_q[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_done) begin
                        state <= S_STOP;
                        tx_q  <= IDLE_LEVEL;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_done) begin
                        if (change) begin
                            // Live input beats the pending slot; a valid pending byte is lost.
                            shift_q       <= bus.data_in;
                            overrun_q     <= pending_valid;
                            pending_valid <= 1'b0;
                            state         <= S_START;
                            tx_q          <= 1'b0;
                        end else if (pending_valid) begin
                            shift_q       <= pending_q;
                            pending_valid <= 1'b0;
                            state         <= S_START;
                            tx_q          <= 1'b0;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    tx_q   <= IDLE_LEVEL;
                    busy_q <= 1'b0;
                end
            endcase

            // Mid-frame change parks in the pending slot, overwriting any older one.
            if (state != S_IDLE && change && !stop_end) begin
                pending_q     <= bus.data_in;
                pending_valid <= 1'b1;
                overrun_q     <= pending_valid;
            end
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_uart_tx_on_change.sv
// Scoreboard bench: a time-based reference model predicts line level, busy and
// overrun per cycle and queues the bytes that should appear; a monitor decodes
// frames from the line and checks them against the queue.
module tb_uart_tx_on_change;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_on_change_if bus ();

    uart_tx_on_change #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] prev   = 8'h00;
    bit         act    = 0;
    int         fstart = 0;
    logic [7:0] fbyte  = 8'h00;
    bit         pend_v = 0;
    logic [7:0] pend_b = 8'h00;
    int         cyc    = 0;
    logic       exp_tx = 1'b1;
    logic       exp_busy = 1'b0;
    logic       exp_ov = 1'b0;
    logic [7:0] exp_q[$];

    task automatic start_frame(input logic [7:0] b);
        act    = 1;
        fstart = cyc;
        fbyte  = b;
        exp_q.push_back(b);
    endtask

    // Apply the rules for one clock edge that sampled d.
    task automatic model_edge(input logic [7:0] d);
        bit chg;
        int idx;
        chg    = (d != prev);
        prev   = d;
        exp_ov = 1'b0;
        if (act && cyc == fstart + FRAME) begin
            if (chg) begin
                exp_ov = pend_v;
                pend_v = 0;
                start_frame(d);
            end else if (pend_v) begin
                pend_v = 0;
                start_frame(pend_b);
            end else begin
                act = 0;
            end
        end else if (act) begin
            if (chg) begin
                exp_ov = pend_v;
                pend_v = 1;
                pend_b = d;
            end
        end else if (chg) begin
            start_frame(d);
        end
        if (!act) begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
        end else begin
            exp_busy = 1'b1;
            idx = (cyc - fstart) / CPB;
            if (idx == 0)       exp_tx = 1'b0;
            else if (idx <= 8)  exp_tx = fbyte[idx-1];
            else if (idx == NB - 1) exp_tx = 1'b1;
            else                exp_tx = ^fbyte;
        end
    endtask

    task automatic step(input logic [7:0] d);
        @(negedge clk);
        bus.data_in = d;
        @(posedge clk);
        cyc++;
        model_edge(d);
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
        end
    endtask

    // Called right after a posedge: reset mid-cycle, check the async response, release mid-cycle.
    task automatic do_reset(input int hold);
        #2 rst = 1'b1;
        #1;
        check1("rst_tx", bus.tx, 1'b1);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_overrun", bus.overrun, 1'b0);
        act = 0; pend_v = 0; prev = 8'h00;
        exp_tx = 1'b1; exp_busy = 1'b0; exp_ov = 1'b0;
        exp_q.delete();
        repeat (hold) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Per-cycle line checks and frame decoding.
    int         mcnt = 0;
    bit         mact = 0;
    logic [15:0] word = '0;
    always @(negedge clk) begin
        logic [7:0] e;
        check1("tx", bus.tx, exp_tx);
        check1("busy", bus.busy, exp_busy);
        check1("overrun", bus.overrun, exp_ov);
        if (rst) begin
            mact = 0;
        end else begin
            if (!mact && bus.tx == 1'b0) begin
                mact = 1;
                mcnt = 0;
            end
            if (mact) begin
                if (mcnt % CPB == CPB / 2) word[mcnt / CPB] = bus.tx;
                if (mcnt == (NB - 1) * CPB + CPB / 2) begin
                    mact = 0;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL frame_unexpected cyc=%0d got=%h exp=none", cyc, word[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        if (word[8:1] !== e || word[0] !== 1'b0 || word[NB-1] !== 1'b1
`ifdef UART_TX_PARITY_EN
                            || word[9] !== ^e
`endif
                           ) begin
                            miscompares++;
                            $display("FAIL frame cyc=%0d got=%h (raw %h) exp=%h", cyc, word[8:1], word, e);
                        end
                    end
                end
                mcnt++;
            end
        end
    end

    initial begin
        logic [7:0] d;
        int hold;
        bus.data_in = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Quiet after reset: no frame
        repeat (50) step(8'h00);
        // Single frame 0x05
        repeat (60) step(8'h05);
        // 0x03 then 0x07 mid-frame: back-to-back, no overrun
        repeat (10) step(8'h03);
        repeat (90) step(8'h07);
        // 0x01, 0x02 at +8, 0x04 at +12: 0x02 dropped with overrun
        repeat (8) step(8'h01);
        repeat (4) step(8'h02);
        repeat (90) step(8'h04);
        // Change exactly at stop end with a pending byte: live value wins, overrun
        repeat (15) step(8'h11);
        repeat (25) step(8'h22);
        repeat (90) step(8'h33);
        // Reset mid-frame, then the unchanged 0x06 is resent
        repeat (20) step(8'h06);
        do_reset(3);
        repeat (60) step(8'h06);
        // Random changes with random hold times
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            hold = $urandom_range(1, 50);
            repeat (hold) step(d);
        end
        // Drain
        repeat (2 * FRAME + 10) step(d);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got=%0d exp=0 frames outstanding", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
